// File: rtl/pipeline_control_unit.sv
// Pipeline enable/flush control: arbitrates memory freeze, branch redirect and load-use stall,
// tracks memory waits (RUN/WAIT) with a sticky timeout, and keeps saturating stall/flush counters.
module pipeline_control_unit #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              branch_taken_e,
  input  logic [ADDR_W-1:0] branch_target_e,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_en,
  output logic              de_flush,
  output logic              em_en,
  output logic              mw_en,
  output logic              mw_bubble,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              mem_wait,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             freeze;
  logic             stall_applied;

  assign freeze        = dmem_req_m && !dmem_ready;
  assign stall_applied = freeze || (stall_req && !branch_taken_e);
  assign pc_target     = branch_target_e;
  assign mem_wait      = (state == ST_WAIT);

  // Value the wait counter takes on this edge if the freeze continues.
  always_comb begin
    wait_nxt = CNT_W'(1);
    if (state == ST_WAIT)
      wait_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  // Priority: reset, memory freeze, branch redirect, load-use stall, normal flow.
  always_comb begin
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    fd_flush    = 1'b0;
    de_en       = 1'b1;
    de_flush    = 1'b0;
    em_en       = 1'b1;
    mw_en       = 1'b1;
    mw_bubble   = 1'b0;
    pc_redirect = 1'b0;
    if (rst) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_en     = 1'b0;
      em_en     = 1'b0;
      mw_en     = 1'b0;
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      mw_bubble = 1'b1;
    end else if (freeze) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_en     = 1'b0;
      em_en     = 1'b0;
      mw_en     = 1'b0;
      mw_bubble = 1'b1;
    end else if (branch_taken_e) begin
      fd_flush    = 1'b1;
      de_flush    = 1'b1;
      pc_redirect = 1'b1;
    end else if (stall_req) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (freeze) begin
            state    <= ST_WAIT;
            wait_cnt <= wait_nxt;
          end
        end
        ST_WAIT: begin
          if (freeze) begin
            wait_cnt <= wait_nxt;
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
      // Sticky: only reset clears it.
      if (freeze && wait_nxt == WAIT_LIMIT)
        mem_timeout <= 1'b1;
      if (stall_applied && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_redirect && flush_count != CNT_MAX)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
